// File: rtl/mem_bist_pkg.sv
// Shared types and the test-pattern generator for the memory write/readback sequencer.
package mem_bist_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} bist_state_e;

  localparam int PAT_W = 32;

  // P(a) = 2*a; callers truncate to the memory width, which gives the mod 2^WIDTH wrap.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] a, input logic inv);
    logic [PAT_W-1:0] p;
    p = a << 1;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_bist_seq_if.sv
// Single-port memory bus between the BIST sequencer (master) and the memory (slave).
interface mem_bist_seq_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             mem_write_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data_in;
  logic [WIDTH-1:0] mem_data_out;

  modport master (output mem_write_en, mem_addr, mem_data_in, input mem_data_out);
  modport slave  (input mem_write_en, mem_addr, mem_data_in, output mem_data_out);
endinterface

// File: rtl/mem_bist_cmp.sv
// Readback checker: one-stage expected-value pipeline, comparator, error count and
// first-failing-address capture.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            issue,
  input  logic [$clog2(DEPTH)-1:0]        addr,
  input  logic [WIDTH-1:0]                exp,
  input  logic [WIDTH-1:0]                rdata,
  output logic [$clog2(2*DEPTH+1)-1:0]    err_count,
  output logic [$clog2(DEPTH)-1:0]        first_err_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = $clog2(2*DEPTH+1);

  logic             vld;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] exp_q;
  logic             mismatch;

  // The memory returns data one cycle after the address is issued, so the
  // issued address/expected value ride alongside for exactly one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= 1'b0;
      addr_q <= '0;
      exp_q  <= '0;
    end else begin
      vld    <= issue && !clr;
      addr_q <= addr;
      exp_q  <= exp;
    end
  end

  assign mismatch = vld && (rdata != exp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      err_count <= EW'(err_count + 1'b1);
      if (err_count == '0) first_err_addr <= addr_q;
    end
  end

endmodule

// File: rtl/mem_bist_seq.sv
// Memory BIST sequencer: fills every address with P(a), reads back and reports results.
// Define MEM_BIST_INVERT_PASS_EN to add a second write/read pass using ~P(a).
module mem_bist_seq
  import mem_bist_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [$clog2(2*DEPTH+1)-1:0]  err_count,
  output logic [$clog2(DEPTH)-1:0]      first_err_addr,
  mem_bist_seq_if.master                mem
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_WRITE = WRITE;
  localparam logic [2:0] ST_READ  = READ;
  localparam logic [2:0] ST_DRAIN = DRAIN;
  localparam logic [2:0] ST_DONE  = DONE;

  function automatic logic [WIDTH-1:0] pat_w(input logic [AW-1:0] a, input logic i);
    return WIDTH'(pattern(PAT_W'(a), i));
  endfunction

  logic [2:0]    state;
  logic          inv;
  logic          last;
  logic          launch;
  logic [AW-1:0] addr_nxt;

  assign last     = (mem.mem_addr == AW'(DEPTH-1));
  assign launch   = start && (state == ST_IDLE || state == ST_DONE);
  assign addr_nxt = AW'(mem.mem_addr + 1'b1);

  assign busy = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
  assign pass = done && (err_count == '0);

  // mem_addr doubles as the address counter so the memory side stays registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      inv              <= 1'b0;
      done             <= 1'b0;
      mem.mem_write_en <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_data_in  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state            <= ST_WRITE;
            inv              <= 1'b0;
            done             <= 1'b0;
            mem.mem_write_en <= 1'b1;
            mem.mem_addr     <= '0;
            mem.mem_data_in  <= pat_w('0, 1'b0);
          end else if (state == ST_DONE) begin
            done <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (last) begin
            state            <= ST_READ;
            mem.mem_write_en <= 1'b0;
            mem.mem_addr     <= '0;
            mem.mem_data_in  <= '0;
          end else begin
            mem.mem_addr    <= addr_nxt;
            mem.mem_data_in <= pat_w(addr_nxt, inv);
          end
        end
        ST_READ: begin
          if (last) begin
            state        <= ST_DRAIN;
            mem.mem_addr <= '0;
          end else begin
            mem.mem_addr <= addr_nxt;
          end
        end
        ST_DRAIN: begin
`ifdef MEM_BIST_INVERT_PASS_EN
          if (!inv) begin
            state            <= ST_WRITE;
            inv              <= 1'b1;
            mem.mem_write_en <= 1'b1;
            mem.mem_addr     <= '0;
            mem.mem_data_in  <= pat_w('0, 1'b1);
          end else begin
            state <= ST_DONE;
          end
`else
          state <= ST_DONE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_bist_cmp #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_cmp (
    .clk            (clk),
    .rst            (rst),
    .clr            (launch),
    .issue          (state == ST_READ),
    .addr           (mem.mem_addr),
    .exp            (pat_w(mem.mem_addr, inv)),
    .rdata          (mem.mem_data_out),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: doc/mem_bist_seq.md
# mem_bist_seq

Synthesizable write-then-readback sequencer that drives the single-port `memory` block's `write_en`/`addr`/`data_in` interface and checks `data_out`. On a start pulse it fills every address with a deterministic pattern, reads every address back, compares against the expected value, and reports pass/fail, an error count and the first failing address. It sits between a control/status register front end and one `memory` instance. It replaces bench-driven fill/readback with an on-chip initiator.

## Interface
- `DEPTH`, 16, number of memory words; any value ≥ 2, not necessarily a power of two.
- `WIDTH`, 8, memory data width; ≥ 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; honoured only in IDLE or DONE.
- `busy` out 1: high in WRITE, READ and DRAIN.
- `done` out 1: high in DONE; holds until the next accepted `start` or `rst`.
- `pass` out 1: valid while `done`; 1 iff `err_count == 0`.
- `err_count` out `$clog2(2*DEPTH+1)`: number of mismatching reads in this run.
- `first_err_addr` out `$clog2(DEPTH)`: address of the first mismatch; 0 if none.
- `mem_write_en` out 1: drives memory `write_en`.
- `mem_addr` out `$clog2(DEPTH)`: drives memory `addr`.
- `mem_data_in` out `WIDTH`: drives memory `data_in`.
- `mem_data_out` in `WIDTH`: from memory `data_out`; one-cycle registered read latency.

## Operation
- Pattern P(a) = (a*2) mod 2^WIDTH. The product is computed at WIDTH+1 bits and truncated. Example: WIDTH=4, a=9 gives 2.
- States: IDLE → WRITE → READ → DRAIN → DONE.
- IDLE or DONE with `start` = 1: clear `err_count`, `first_err_addr` and the address counter; go to WRITE.
- WRITE: `mem_write_en` = 1, `mem_addr` = a, `mem_data_in` = P(a). `a` counts 0..DEPTH-1. After a = DEPTH-1, reset a to 0 and go to READ.
- READ: `mem_write_en` = 0, `mem_addr` = a for a = 0..DEPTH-1. A one-stage pipeline holds the issued address and its expected value. Each cycle after an issue, compare `mem_data_out` with the expected value.
- DRAIN: one cycle that compares the last read, then go to DONE.
- Mismatch handling: increment `err_count`. If it was 0, load `first_err_addr` with the pipelined address.
- `start` in WRITE, READ or DRAIN is ignored.
- Address counters wrap explicitly at DEPTH-1. `mem_addr` never reaches DEPTH.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0, `mem_write_en`=0, `mem_addr`=0, `mem_data_in`=0. State returns to IDLE.
- `rst` mid-run: abort immediately and asynchronously to the reset values above. No partial result is retained.
- `start` sampled high at edge 0: WRITE occupies cycles 1..DEPTH, READ occupies cycles DEPTH+1..2*DEPTH, DRAIN is cycle 2*DEPTH+1. `done` rises at edge 2*DEPTH+2.
- For DEPTH=16, `done` is first high 34 cycles after the `start` edge.
- All memory-side outputs are registered. `mem_write_en` deasserts on the same edge READ begins.
- `pass` = (`err_count` == 0) && `done`.

## Configuration
- `MEM_BIST_INVERT_PASS_EN` defined: after DRAIN, run a second WRITE/READ/DRAIN pass with pattern ~P(a) before DONE.
  - Errors from both passes accumulate in `err_count`.
  - `first_err_addr` keeps the earliest mismatch from either pass.
  - `done` latency becomes 4*DEPTH+3 edges.
- Macro undefined: single pass only. `err_count` keeps the same declared width.

## Structure
- Shared package `mem_bist_pkg`: state enum `bist_state_e` (IDLE, WRITE, READ, DRAIN, DONE) and a `pattern(a, inv)` function returning P(a) or ~P(a).
- One sub-module, `mem_bist_cmp`: the one-stage expected-value pipeline, comparator and error counter/first-address capture.

## Test plan
- DEPTH=16, WIDTH=8, fault-free `memory`, pulse `start` → `done` after 34 cycles, `pass`=1, `err_count`=0, readback of address 15 = 0x1E.
- Memory model with `data_out` bit 0 stuck at 1 → `err_count`=16, `first_err_addr`=0, `pass`=0.
  - With `MEM_BIST_INVERT_PASS_EN`: still 16, since every second-pass word has bit 0 = 1.
- Memory with address 5 corrupted to 0xFF → `err_count`=1, `first_err_addr`=5.
- `start` re-pulsed at cycles 3 and 20 of a run → ignored; `done` still arrives at cycle 34. A `start` in DONE relaunches with counts cleared.
- `rst` asserted during WRITE (address 7) → all outputs return to reset values asynchronously. A subsequent `start` completes normally with `pass`=1.
- DEPTH=10, WIDTH=4 → addresses 0..9 only; address 9 writes and expects 2; `pass`=1.
